mesi_isc_bus_monitor: RTL and testbench

Synthesizable, parametrised protocol monitor for the MESI intersection controller: it observes every main-bus and coherence-bus port of `mesi_isc` and flags protocol violations as sticky error bits, with first-error capture and a completion counter. It generalises the controller's formal checks from three to CPU_NUM ports. It turns unbounded "ack eventually" properties into bounded timeouts, so the same checks run in simulation, emulation and silicon debug. It sits beside `mesi_isc` at the top level and drives only observation outputs.

---
 rtl/mesi_isc_bus_monitor_if.sv | 17 +
 rtl/mesi_isc_bus_monitor.sv | 243 ++++++++++++++++++++++++
 tb/tb_mesi_isc_bus_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_bus_monitor_if.sv
// Bundle of the mesi_isc main-bus and coherence-bus signals seen by the monitor.
// The master side drives the bus; the slave side only observes it.
interface mesi_isc_bus_monitor_if #(
   parameter int CPU_NUM        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3
);
   logic [CPU_NUM*MBUS_CMD_WIDTH-1:0] mbus_cmd;
   logic [CPU_NUM*ADDR_WIDTH-1:0]     mbus_addr;
   logic [CPU_NUM-1:0]                mbus_ack;
   logic [CPU_NUM*CBUS_CMD_WIDTH-1:0] cbus_cmd;
   logic [CPU_NUM-1:0]                cbus_ack;

   modport master (output mbus_cmd, mbus_addr, mbus_ack, cbus_cmd, cbus_ack);
   modport slave  (input  mbus_cmd, mbus_addr, mbus_ack, cbus_cmd, cbus_ack);
endinterface

// File: rtl/mesi_isc_bus_monitor.sv
// Protocol monitor for the MESI intersection controller: per-port request and snoop
// trackers with bounded ack timeouts, sticky error bits, first-error capture and counters.
module mesi_isc_bus_monitor #(
   parameter int CPU_NUM        = 4,
   parameter int CPU_NUM_LOG2   = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int ACK_TIMEOUT    = 64,
   parameter int TMR_WIDTH      = 8,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   mesi_isc_bus_monitor_if.slave   bus,
   input  logic                    err_clr_i,
   output logic                    err_o,
   output logic [7:0]              err_vec_o,
   output logic [CPU_NUM_LOG2-1:0] first_err_port_o,
   output logic [2:0]              first_err_code_o,
   output logic [CNT_WIDTH-1:0]    first_err_cycle_o,
   output logic [CNT_WIDTH-1:0]    done_cnt_o
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_LATE = 2'd2;
   localparam int CW = $clog2(CPU_NUM + 1);
   localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP = MBUS_CMD_WIDTH'(0);
   localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR  = MBUS_CMD_WIDTH'(1);
   localparam logic [MBUS_CMD_WIDTH-1:0] MB_MAX = MBUS_CMD_WIDTH'(4);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_MAX = CBUS_CMD_WIDTH'(4);
   // Timer is cleared in the request's first cycle, so it reads k-1 in cycle t0+k.
   localparam logic [TMR_WIDTH-1:0] TMR_LIM = TMR_WIDTH'(ACK_TIMEOUT - 2);

   logic [MBUS_CMD_WIDTH-1:0] m_cmd_s  [CPU_NUM];
   logic [ADDR_WIDTH-1:0]     m_addr_s [CPU_NUM];
   logic [CBUS_CMD_WIDTH-1:0] s_cmd_s  [CPU_NUM];
   logic [CPU_NUM-1:0]        wr_vec_s;
   logic                      multi_wr_s;

   logic [1:0]                m_st_q   [CPU_NUM];
   logic [1:0]                m_st_d   [CPU_NUM];
   logic [TMR_WIDTH-1:0]      m_tmr_q  [CPU_NUM];
   logic [TMR_WIDTH-1:0]      m_tmr_d  [CPU_NUM];
   logic [MBUS_CMD_WIDTH-1:0] m_cmd_q  [CPU_NUM];
   logic [MBUS_CMD_WIDTH-1:0] m_cmd_d  [CPU_NUM];
   logic [ADDR_WIDTH-1:0]     m_addr_q [CPU_NUM];
   logic [ADDR_WIDTH-1:0]     m_addr_d [CPU_NUM];
   logic [1:0]                s_st_q   [CPU_NUM];
   logic [1:0]                s_st_d   [CPU_NUM];
   logic [TMR_WIDTH-1:0]      s_tmr_q  [CPU_NUM];
   logic [TMR_WIDTH-1:0]      s_tmr_d  [CPU_NUM];
   logic [CPU_NUM-1:0]        ack_prev_q;
   logic [7:0]                new_err_s [CPU_NUM];
   logic [CW-1:0]             comp_n_s;
   logic                      wr_seen_s;

   logic [7:0]                err_vec_q, err_vec_d, err_base_s, all_new_s;
   logic                      err_q, err_d;
   logic [CPU_NUM_LOG2-1:0]   first_port_q, first_port_d, cap_port_s;
   logic [2:0]                first_code_q, first_code_d, cap_code_s;
   logic                      cap_found_s;
   logic [CNT_WIDTH-1:0]      first_cycle_q, first_cycle_d;
   logic [CNT_WIDTH-1:0]      cyc_q, done_q, done_d;
   logic [CNT_WIDTH:0]        done_sum_s;

   for (genvar p = 0; p < CPU_NUM; p++) begin : g_slice
      assign m_cmd_s[p]  = bus.mbus_cmd[p*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      assign m_addr_s[p] = bus.mbus_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign s_cmd_s[p]  = bus.cbus_cmd[p*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH];
      assign wr_vec_s[p] = (m_cmd_s[p] == MB_WR);
   end
   // More than one bit set means at least two simultaneous writers.
   assign multi_wr_s = ((wr_vec_s & (wr_vec_s - CPU_NUM'(1))) != '0);

   always_comb begin
      comp_n_s  = '0;
      wr_seen_s = 1'b0;
      for (int p = 0; p < CPU_NUM; p++) begin
         m_st_d[p]   = m_st_q[p];
         m_tmr_d[p]  = m_tmr_q[p];
         m_cmd_d[p]  = m_cmd_q[p];
         m_addr_d[p] = m_addr_q[p];
         s_st_d[p]   = s_st_q[p];
         s_tmr_d[p]  = s_tmr_q[p];
         new_err_s[p]    = 8'd0;
         new_err_s[p][0] = (m_cmd_s[p] > MB_MAX);
         new_err_s[p][1] = (s_cmd_s[p] > CB_MAX);
         new_err_s[p][4] = bus.mbus_ack[p] && ack_prev_q[p];
         new_err_s[p][5] = bus.mbus_ack[p] && (m_cmd_s[p] == MB_NOP);
         new_err_s[p][6] = multi_wr_s && wr_vec_s[p] && !wr_seen_s;
         if (wr_vec_s[p]) begin
            wr_seen_s = 1'b1;
         end else begin
            wr_seen_s = wr_seen_s;
         end

         case (m_st_q[p])
            ST_IDLE: begin
               if ((m_cmd_s[p] != MB_NOP) && (m_cmd_s[p] <= MB_MAX)) begin
                  if (bus.mbus_ack[p]) begin
                     comp_n_s = comp_n_s + CW'(1);
                  end else begin
                     m_st_d[p]   = ST_WAIT;
                     m_tmr_d[p]  = '0;
                     m_cmd_d[p]  = m_cmd_s[p];
                     m_addr_d[p] = m_addr_s[p];
                  end
               end else begin
                  m_st_d[p] = ST_IDLE;
               end
            end
            ST_WAIT, ST_LATE: begin
               if (bus.mbus_ack[p]) begin
                  m_st_d[p] = ST_IDLE;
                  comp_n_s  = comp_n_s + CW'(1);
               end else begin
                  new_err_s[p][2] = (m_cmd_s[p] != m_cmd_q[p]) || (m_addr_s[p] != m_addr_q[p]);
                  if ((m_st_q[p] == ST_WAIT) && (m_tmr_q[p] == TMR_LIM)) begin
                     m_st_d[p]       = ST_LATE;
                     new_err_s[p][3] = 1'b1;
                  end else if (m_st_q[p] == ST_WAIT) begin
                     m_tmr_d[p] = m_tmr_q[p] + TMR_WIDTH'(1);
                  end else begin
                     m_tmr_d[p] = m_tmr_q[p];
                  end
               end
            end
            default: m_st_d[p] = ST_IDLE;
         endcase

         case (s_st_q[p])
            ST_IDLE: begin
               if ((s_cmd_s[p] != CB_NOP) && !bus.cbus_ack[p]) begin
                  s_st_d[p]  = ST_WAIT;
                  s_tmr_d[p] = '0;
               end else begin
                  s_st_d[p] = ST_IDLE;
               end
            end
            ST_WAIT, ST_LATE: begin
               if (bus.cbus_ack[p]) begin
                  s_st_d[p] = ST_IDLE;
               end else if ((s_st_q[p] == ST_WAIT) && (s_tmr_q[p] == TMR_LIM)) begin
                  s_st_d[p]       = ST_LATE;
                  new_err_s[p][7] = 1'b1;
               end else if (s_st_q[p] == ST_WAIT) begin
                  s_tmr_d[p] = s_tmr_q[p] + TMR_WIDTH'(1);
               end else begin
                  s_tmr_d[p] = s_tmr_q[p];
               end
            end
            default: s_st_d[p] = ST_IDLE;
         endcase
      end
   end

   // Sticky error merge and first-error selection: lowest port, then lowest bit.
   always_comb begin
      all_new_s   = 8'd0;
      cap_found_s = 1'b0;
      cap_port_s  = '0;
      cap_code_s  = 3'd0;
      for (int p = 0; p < CPU_NUM; p++) begin
         all_new_s = all_new_s | new_err_s[p];
         for (int b = 0; b < 8; b++) begin
            if (new_err_s[p][b] && !cap_found_s) begin
               cap_found_s = 1'b1;
               cap_port_s  = CPU_NUM_LOG2'(p);
               cap_code_s  = 3'(b);
            end else begin
               cap_found_s = cap_found_s;
            end
         end
      end
      err_base_s = err_clr_i ? 8'd0 : err_vec_q;
      err_vec_d  = err_base_s | all_new_s;
      err_d      = (err_vec_d != 8'd0);
      if ((err_base_s == 8'd0) && cap_found_s) begin
         first_port_d  = cap_port_s;
         first_code_d  = cap_code_s;
         first_cycle_d = cyc_q;
      end else if (err_clr_i) begin
         first_port_d  = '0;
         first_code_d  = 3'd0;
         first_cycle_d = '0;
      end else begin
         first_port_d  = first_port_q;
         first_code_d  = first_code_q;
         first_cycle_d = first_cycle_q;
      end
      done_sum_s = {1'b0, done_q} + (CNT_WIDTH+1)'(comp_n_s);
      if (done_sum_s[CNT_WIDTH]) begin
         done_d = '1;
      end else begin
         done_d = done_sum_s[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < CPU_NUM; p++) begin
            m_st_q[p]   <= ST_IDLE;
            m_tmr_q[p]  <= '0;
            m_cmd_q[p]  <= '0;
            m_addr_q[p] <= '0;
            s_st_q[p]   <= ST_IDLE;
            s_tmr_q[p]  <= '0;
         end
         ack_prev_q    <= '0;
         err_vec_q     <= 8'd0;
         err_q         <= 1'b0;
         first_port_q  <= '0;
         first_code_q  <= 3'd0;
         first_cycle_q <= '0;
         cyc_q         <= '0;
         done_q        <= '0;
      end else begin
         m_st_q        <= m_st_d;
         m_tmr_q       <= m_tmr_d;
         m_cmd_q       <= m_cmd_d;
         m_addr_q      <= m_addr_d;
         s_st_q        <= s_st_d;
         s_tmr_q       <= s_tmr_d;
         ack_prev_q    <= bus.mbus_ack;
         err_vec_q     <= err_vec_d;
         err_q         <= err_d;
         first_port_q  <= first_port_d;
         first_code_q  <= first_code_d;
         first_cycle_q <= first_cycle_d;
         cyc_q         <= cyc_q + CNT_WIDTH'(1);
         done_q        <= done_d;
      end
   end

   assign err_o             = err_q;
   assign err_vec_o         = err_vec_q;
   assign first_err_port_o  = first_port_q;
   assign first_err_code_o  = first_code_q;
   assign first_err_cycle_o = first_cycle_q;
   assign done_cnt_o        = done_q;
endmodule

// File: tb/tb_mesi_isc_bus_monitor.sv
// Self-checking bench for mesi_isc_bus_monitor: a table of single-cycle vectors
// followed by hand-written timeout, snoop, reset and address-change sequences.
module tb_mesi_isc_bus_monitor;
   localparam int NP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_clr = 1'b0;
   logic        err;
   logic [7:0]  err_vec;
   logic [1:0]  f_port;
   logic [2:0]  f_code;
   logic [15:0] f_cycle;
   logic [15:0] done_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;
   int cur_cyc = 0;
   int t_cyc  = 0;

   mesi_isc_bus_monitor_if #(.CPU_NUM(NP), .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)) bus_if ();

   mesi_isc_bus_monitor #(
      .CPU_NUM(NP), .CPU_NUM_LOG2(2), .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3),
      .ACK_TIMEOUT(64), .TMR_WIDTH(8), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .err_clr_i(err_clr),
      .err_o(err), .err_vec_o(err_vec), .first_err_port_o(f_port), .first_err_code_o(f_code),
      .first_err_cycle_o(f_cycle), .done_cnt_o(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] mc;
      logic [3:0]  ma;
      logic [11:0] cc;
      logic [3:0]  ca;
      logic        clr;
      logic [7:0]  e_vec;
      logic [1:0]  e_port;
      logic [2:0]  e_code;
      logic [15:0] e_done;
   } vec_t;

   vec_t tbl [23];

   function automatic logic [11:0] pk(input logic [2:0] c3, input logic [2:0] c2,
                                      input logic [2:0] c1, input logic [2:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic step(input logic [11:0] mc, input logic [3:0] ma, input logic [11:0] cc,
                       input logic [3:0] ca, input logic clr);
      bus_if.mbus_cmd = mc;
      bus_if.mbus_ack = ma;
      bus_if.cbus_cmd = cc;
      bus_if.cbus_ack = ca;
      err_clr         = clr;
      cur_cyc         = cyc_n;
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.mbus_cmd = '0;
      bus_if.mbus_ack = '0;
      bus_if.cbus_cmd = '0;
      bus_if.cbus_ack = '0;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc_n = 0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_vec"},   32'(err_vec),  32'h0);
      chk({nm, "_err"},   32'(err),      32'h0);
      chk({nm, "_port"},  32'(f_port),   32'h0);
      chk({nm, "_code"},  32'(f_code),   32'h0);
      chk({nm, "_cycle"}, 32'(f_cycle),  32'h0);
      chk({nm, "_done"},  32'(done_cnt), 32'h0);
   endtask

   initial begin
      //             mc                  ma       cc                 ca       clr   vec    port  code  done
      tbl[0]  = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0};
      tbl[1]  = '{pk(3'd0,3'd0,3'd4,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0};
      tbl[2]  = '{pk(3'd0,3'd0,3'd4,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0};
      tbl[3]  = '{pk(3'd0,3'd0,3'd4,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0};
      tbl[4]  = '{pk(3'd0,3'd0,3'd4,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0};
      tbl[5]  = '{pk(3'd0,3'd0,3'd4,3'd0), 4'b0010, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd1};
      tbl[6]  = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd1};
      tbl[7]  = '{pk(3'd0,3'd0,3'd0,3'd1), 4'b0001, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd2};
      tbl[8]  = '{pk(3'd0,3'd2,3'd0,3'd0), 4'b0100, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd3};
      tbl[9]  = '{pk(3'd0,3'd2,3'd0,3'd0), 4'b0100, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h10, 2'd2, 3'd4, 16'd4};
      tbl[10] = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b1, 8'h00, 2'd0, 3'd0, 16'd4};
      tbl[11] = '{pk(3'd0,3'd1,3'd0,3'd1), 4'b1000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h60, 2'd0, 3'd6, 16'd4};
      tbl[12] = '{pk(3'd0,3'd1,3'd0,3'd1), 4'b0101, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h60, 2'd0, 3'd6, 16'd6};
      tbl[13] = '{pk(3'd0,3'd0,3'd7,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b1, 8'h01, 2'd1, 3'd0, 16'd6};
      tbl[14] = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0010, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h21, 2'd1, 3'd0, 16'd6};
      tbl[15] = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd5,3'd0,3'd0,3'd0), 4'b1000, 1'b1, 8'h02, 2'd3, 3'd1, 16'd6};
      tbl[16] = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b1, 8'h00, 2'd0, 3'd0, 16'd6};
      tbl[17] = '{pk(3'd3,3'd0,3'd0,3'd2), 4'b1000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd7};
      tbl[18] = '{pk(3'd0,3'd0,3'd0,3'd1), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h04, 2'd0, 3'd2, 16'd7};
      tbl[19] = '{pk(3'd0,3'd0,3'd0,3'd1), 4'b0001, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h04, 2'd0, 3'd2, 16'd8};
      tbl[20] = '{pk(3'd0,3'd0,3'd0,3'd2), 4'b0000, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b1, 8'h00, 2'd0, 3'd0, 16'd8};
      tbl[21] = '{pk(3'd0,3'd0,3'd0,3'd2), 4'b0001, pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0, 16'd9};
      tbl[22] = '{pk(3'd0,3'd0,3'd0,3'd0), 4'b0000, pk(3'd0,3'd1,3'd0,3'd0), 4'b0100, 1'b0, 8'h00, 2'd0, 3'd0, 16'd9};

      bus_if.mbus_addr = {32'h0000_00C0, 32'h0000_0080, 32'h0000_0040, 32'h0000_0000};
      do_reset();
      chk_all_zero("reset");

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].mc, tbl[i].ma, tbl[i].cc, tbl[i].ca, tbl[i].clr);
         chk($sformatf("v%0d_vec", i),  32'(err_vec),  32'(tbl[i].e_vec));
         chk($sformatf("v%0d_err", i),  32'(err),      32'(tbl[i].e_vec != 8'h00));
         chk($sformatf("v%0d_port", i), 32'(f_port),   32'(tbl[i].e_port));
         chk($sformatf("v%0d_code", i), 32'(f_code),   32'(tbl[i].e_code));
         chk($sformatf("v%0d_done", i), 32'(done_cnt), 32'(tbl[i].e_done));
      end

      // Port 0 WR never acked: flag appears after exactly 64 cycles.
      for (int k = 1; k <= 64; k++) begin
         step(pk(3'd0,3'd0,3'd0,3'd1), 4'b0000, 12'h000, 4'b0000, 1'b0);
         if (k == 63) chk("to_pre_vec", 32'(err_vec), 32'h00);
         if (k == 64) t_cyc = cur_cyc;
      end
      chk("to_vec",   32'(err_vec), 32'h08);
      chk("to_port",  32'(f_port),  32'd0);
      chk("to_code",  32'(f_code),  32'd3);
      chk("to_cycle", 32'(f_cycle), 32'(t_cyc));
      step(pk(3'd0,3'd0,3'd0,3'd1), 4'b0000, 12'h000, 4'b0000, 1'b1);
      chk("late_clr_vec", 32'(err_vec), 32'h00);
      repeat (70) step(pk(3'd0,3'd0,3'd0,3'd1), 4'b0000, 12'h000, 4'b0000, 1'b0);
      chk("late_noreflag_vec", 32'(err_vec), 32'h00);
      step(pk(3'd0,3'd0,3'd0,3'd1), 4'b0001, 12'h000, 4'b0000, 1'b0);
      chk("late_ack_done", 32'(done_cnt), 32'd10);
      chk("late_ack_vec",  32'(err_vec),  32'h00);

      // Ack in the last allowed cycle does not flag.
      repeat (63) step(pk(3'd0,3'd0,3'd2,3'd0), 4'b0000, 12'h000, 4'b0000, 1'b0);
      step(pk(3'd0,3'd0,3'd2,3'd0), 4'b0010, 12'h000, 4'b0000, 1'b0);
      chk("edge_vec",  32'(err_vec),  32'h00);
      chk("edge_done", 32'(done_cnt), 32'd11);
      step(12'h000, 4'b0000, 12'h000, 4'b0000, 1'b0);
      chk("edge_vec2", 32'(err_vec), 32'h00);

      // Port 3 WR_SNOOP never acked.
      for (int k = 1; k <= 64; k++) begin
         step(12'h000, 4'b0000, pk(3'd1,3'd0,3'd0,3'd0), 4'b0000, 1'b0);
         if (k == 63) chk("snp_pre_vec", 32'(err_vec), 32'h00);
      end
      chk("snp_vec",  32'(err_vec), 32'h80);
      chk("snp_port", 32'(f_port),  32'd3);
      chk("snp_code", 32'(f_code),  32'd7);
      step(12'h000, 4'b0000, pk(3'd1,3'd0,3'd0,3'd0), 4'b1000, 1'b0);

      // Reset mid-WAIT (timer 30) with sticky errors pending.
      repeat (31) step(pk(3'd0,3'd1,3'd0,3'd0), 4'b0000, 12'h000, 4'b0000, 1'b0);
      do_reset();
      chk_all_zero("rst_mid");
      repeat (70) step(12'h000, 4'b0000, 12'h000, 4'b0000, 1'b0);
      chk("rst_mid_after_vec", 32'(err_vec), 32'h00);

      // Port 1 address changes while waiting.
      bus_if.mbus_addr[63:32] = 32'h0000_0100;
      step(pk(3'd0,3'd0,3'd2,3'd0), 4'b0000, 12'h000, 4'b0000, 1'b0);
      chk("addr_hold_vec", 32'(err_vec), 32'h00);
      bus_if.mbus_addr[63:32] = 32'h0000_0104;
      step(pk(3'd0,3'd0,3'd2,3'd0), 4'b0000, 12'h000, 4'b0000, 1'b0);
      chk("addr_chg_vec",  32'(err_vec), 32'h04);
      chk("addr_chg_port", 32'(f_port),  32'd1);
      chk("addr_chg_code", 32'(f_code),  32'd2);
      step(pk(3'd0,3'd0,3'd2,3'd0), 4'b0010, 12'h000, 4'b0000, 1'b1);
      chk("addr_ack_vec",  32'(err_vec),  32'h00);
      chk("addr_ack_done", 32'(done_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
